// File: rtl/umi_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : umi_tx_sched
// Purpose  : Round-robin, burst-locking scheduler feeding one UMI packer.
// Revision : 1.0 - initial release
// ============================================================================
module umi_tx_sched #(
    parameter int N   = 4,
    parameter int AW  = 64,
    parameter int BLW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [8*N-1:0]    req_opcode,
    input  logic [4*N-1:0]    req_size,
    input  logic [20*N-1:0]   req_user,
    input  logic [AW*N-1:0]   req_dstaddr,
    input  logic [AW*N-1:0]   req_srcaddr,
    input  logic [4*AW*N-1:0] req_data,
    input  logic [BLW*N-1:0]  req_beats,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        opcode,
    output logic [3:0]        size,
    output logic [19:0]       user,
    output logic              burst,
    output logic [AW-1:0]     dstaddr,
    output logic [AW-1:0]     srcaddr,
    output logic [4*AW-1:0]   data,
    output logic [N-1:0]      grant
);

    localparam int         PW      = (N > 1) ? $clog2(N) : 1;
    localparam int         DW      = 4 * AW;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]     r_state, w_state_nxt;
    logic [PW-1:0]  r_ptr, w_ptr_nxt;
    logic [PW-1:0]  r_lock, w_lock_nxt;
    logic [BLW-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]  w_pick, w_sel;
    logic [PW:0]    w_sum;
    logic           w_pick_vld;
    logic           w_slot_free;
    logic           w_xfer;
    logic [N-1:0]   w_ready;
    logic [N-1:0]   w_onehot;
    logic [BLW-1:0] w_beats;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] x);
        return (x == PW'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    assign w_slot_free = ~out_valid | out_ready;

    // Descending scan so the smallest offset from the pointer wins.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_sum      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PW + 1)'(k);
            if (w_sum >= (PW + 1)'(N)) begin
                w_sum = w_sum - (PW + 1)'(N);
            end
            if (req_valid[w_sum[PW-1:0]]) begin
                w_pick     = w_sum[PW-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_sel   = (r_state == S_IDLE) ? w_pick : r_lock;
        if (!reset) begin
            if (r_state == S_IDLE) begin
                if (w_pick_vld) begin
                    w_ready[w_pick] = w_slot_free;
                end
            end else begin
                w_ready[r_lock] = w_slot_free;
            end
        end
    end

    assign req_ready = w_ready;
    assign w_xfer    = |(req_valid & w_ready);
    assign w_onehot  = {{(N-1){1'b0}}, 1'b1} << w_sel;
    assign w_beats   = req_beats[int'(w_sel)*BLW +: BLW];

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_lock_nxt = w_pick;
                    if (w_beats == '0) begin
                        w_ptr_nxt = f_inc(w_pick);
                    end else begin
                        w_cnt_nxt   = w_beats;
                        w_state_nxt = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == BLW'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = f_inc(r_lock);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Head beats load every field; burst beats refresh data only.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            burst     <= 1'b0;
            grant     <= '0;
            opcode    <= '0;
            size      <= '0;
            user      <= '0;
            dstaddr   <= '0;
            srcaddr   <= '0;
            data      <= '0;
        end else if (w_xfer) begin
            out_valid <= 1'b1;
            grant     <= w_onehot;
            data      <= req_data[int'(w_sel)*DW +: DW];
            if (r_state == S_IDLE) begin
                burst   <= 1'b0;
                opcode  <= req_opcode[int'(w_sel)*8 +: 8];
                size    <= req_size[int'(w_sel)*4 +: 4];
                user    <= req_user[int'(w_sel)*20 +: 20];
                dstaddr <= req_dstaddr[int'(w_sel)*AW +: AW];
                srcaddr <= req_srcaddr[int'(w_sel)*AW +: AW];
            end else begin
                burst   <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            grant     <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_umi_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_umi_tx_sched
// Purpose  : Directed self-checking bench for umi_tx_sched (N=4, AW=64, BLW=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_umi_tx_sched;

    localparam int N   = 4;
    localparam int AW  = 64;
    localparam int BLW = 8;
    localparam int DW  = 4 * AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [8*N-1:0]    req_opcode;
    logic [4*N-1:0]    req_size;
    logic [20*N-1:0]   req_user;
    logic [AW*N-1:0]   req_dstaddr;
    logic [AW*N-1:0]   req_srcaddr;
    logic [DW*N-1:0]   req_data;
    logic [BLW*N-1:0]  req_beats;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        opcode;
    logic [3:0]        size;
    logic [19:0]       user;
    logic              burst;
    logic [AW-1:0]     dstaddr;
    logic [AW-1:0]     srcaddr;
    logic [DW-1:0]     data;
    logic [N-1:0]      grant;

    int checks   = 0;
    int failures = 0;

    umi_tx_sched #(.N(N), .AW(AW), .BLW(BLW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_size(req_size), .req_user(req_user),
        .req_dstaddr(req_dstaddr), .req_srcaddr(req_srcaddr),
        .req_data(req_data), .req_beats(req_beats),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .size(size), .user(user), .burst(burst),
        .dstaddr(dstaddr), .srcaddr(srcaddr), .data(data), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] opcode_of(int r);
        return 8'(8'h10 + r);
    endfunction

    function automatic logic [AW-1:0] dst_of(int r);
        return 64'h1000_0000 + 64'(r * 256);
    endfunction

    function automatic logic [DW-1:0] data_of(int r, int b);
        return {32'(r), 32'(b), 64'hC0FF_EE00_0000_0000 | 64'(r), 128'(b * 7 + r)};
    endfunction

    task automatic set_req(int r, bit v, int beats, int b);
        req_valid[r]              = v;
        req_opcode[r*8 +: 8]      = opcode_of(r);
        req_size[r*4 +: 4]        = 4'(r + 1);
        req_user[r*20 +: 20]      = 20'(20'hA0000 + r);
        req_dstaddr[r*AW +: AW]   = dst_of(r);
        req_srcaddr[r*AW +: AW]   = 64'h2000_0000 + 64'(r);
        req_data[r*DW +: DW]      = data_of(r, b);
        req_beats[r*BLW +: BLW]   = BLW'(beats);
    endtask

    task automatic set_data(int r, int b);
        req_data[r*DW +: DW] = data_of(r, b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int bad;
        bit done;

        reset     = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 0, 0);
        repeat (3) step();
        chk("rst_out_valid", DW'(out_valid), DW'(0));
        chk("rst_grant", DW'(grant), DW'(0));
        chk("rst_burst", DW'(burst), DW'(0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_opcode", DW'(opcode), DW'(0));
        chk("rst_data", data, DW'(0));
        reset = 1'b0;

        // Single beats, all requesters valid: strict rotation.
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_valid", DW'(out_valid), DW'(1));
            chk("rr_grant", DW'(grant), DW'(4'b0001 << (i % 4)));
            chk("rr_burst", DW'(burst), DW'(0));
            chk("rr_opcode", DW'(opcode), DW'(opcode_of(i % 4)));
        end
        req_valid = '0;
        step();
        chk("idle_valid", DW'(out_valid), DW'(0));
        chk("idle_grant", DW'(grant), DW'(0));

        // Move pointer to 2, then burst of 4 from requester 2.
        set_req(1, 1'b1, 0, 0);
        step();
        chk("pre_grant", DW'(grant), DW'(4'b0010));
        set_req(0, 1'b1, 0, 0);
        set_req(2, 1'b1, 3, 0);
        set_req(3, 1'b1, 0, 0);
        #1;
        chk("b4_ready", DW'(req_ready), DW'(4'b0100));
        step();
        chk("b4_head_grant", DW'(grant), DW'(4'b0100));
        chk("b4_head_burst", DW'(burst), DW'(0));
        chk("b4_head_data", data, data_of(2, 0));
        req_opcode[2*8 +: 8] = 8'hEE;
        req_beats[2*BLW +: BLW] = '0;
        for (int b = 1; b < 4; b++) begin
            set_data(2, b);
            step();
            chk("b4_grant", DW'(grant), DW'(4'b0100));
            chk("b4_burst", DW'(burst), DW'(1));
            chk("b4_opcode", DW'(opcode), DW'(opcode_of(2)));
            chk("b4_dstaddr", DW'(dstaddr), DW'(dst_of(2)));
            chk("b4_data", data, data_of(2, b));
        end
        step();
        chk("b4_next_grant", DW'(grant), DW'(4'b1000));
        chk("b4_next_burst", DW'(burst), DW'(0));
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 0, 0);

        // Backpressure on the second beat of a 3-beat burst from requester 0.
        set_req(0, 1'b1, 2, 0);
        step();
        chk("bp_head_grant", DW'(grant), DW'(4'b0001));
        set_data(0, 1);
        step();
        chk("bp_beat2_data", data, data_of(0, 1));
        set_data(0, 2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready_low", DW'(req_ready), DW'(0));
            step();
            chk("bp_hold_valid", DW'(out_valid), DW'(1));
            chk("bp_hold_data", data, data_of(0, 1));
            chk("bp_hold_burst", DW'(burst), DW'(1));
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_back", DW'(req_ready), DW'(4'b0001));
        step();
        chk("bp_beat3_data", data, data_of(0, 2));
        chk("bp_beat3_grant", DW'(grant), DW'(4'b0001));
        set_req(0, 1'b0, 0, 0);
        step();
        chk("bp_drain_valid", DW'(out_valid), DW'(0));

        // Locked requester 1 stalls for 3 cycles; others must not be granted.
        set_req(0, 1'b1, 0, 0);
        set_req(1, 1'b1, 2, 0);
        set_req(2, 1'b1, 0, 0);
        set_req(3, 1'b1, 0, 0);
        step();
        chk("gap_head_grant", DW'(grant), DW'(4'b0010));
        req_valid[1] = 1'b0;
        set_data(1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("gap_valid", DW'(out_valid), DW'(0));
            chk("gap_grant", DW'(grant), DW'(0));
        end
        req_valid[1] = 1'b1;
        step();
        chk("gap_b2_grant", DW'(grant), DW'(4'b0010));
        chk("gap_b2_data", data, data_of(1, 1));
        set_data(1, 2);
        step();
        chk("gap_b3_data", data, data_of(1, 2));
        chk("gap_b3_burst", DW'(burst), DW'(1));
        step();
        chk("gap_next_grant", DW'(grant), DW'(4'b0100));

        // Reset during beat 2 of a 5-beat burst from requester 3.
        for (int r = 0; r < N; r++) set_req(r, 1'b0, 0, 0);
        set_req(3, 1'b1, 4, 0);
        step();
        chk("rb_head_grant", DW'(grant), DW'(4'b1000));
        set_data(3, 1);
        step();
        chk("rb_beat2_data", data, data_of(3, 1));
        reset = 1'b1;
        #1;
        chk("rb_ready_in_rst", DW'(req_ready), DW'(0));
        step();
        chk("rb_valid", DW'(out_valid), DW'(0));
        chk("rb_grant", DW'(grant), DW'(0));
        chk("rb_burst", DW'(burst), DW'(0));
        reset = 1'b0;
        for (int r = 0; r < N; r++) set_req(r, 1'b1, 0, 0);
        step();
        chk("rb_first_grant", DW'(grant), DW'(4'b0001));
        chk("rb_first_burst", DW'(burst), DW'(0));

        // Maximum burst: 255 extra beats from requester 1.
        set_req(0, 1'b0, 0, 0);
        set_req(1, 1'b1, 255, 0);
        set_req(2, 1'b1, 0, 0);
        set_req(3, 1'b0, 0, 0);
        step();
        chk("max_head_grant", DW'(grant), DW'(4'b0010));
        chk("max_head_burst", DW'(burst), DW'(0));
        req_beats[1*BLW +: BLW] = '0;
        cnt  = 1;
        bad  = 0;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            set_data(1, cnt);
            step();
            if (out_valid && grant == 4'b0010) begin
                if (!burst || data !== data_of(1, cnt)) bad++;
                cnt++;
            end else begin
                done = 1'b1;
            end
        end
        chk("max_beats", DW'(cnt), DW'(256));
        chk("max_beat_errors", DW'(bad), DW'(0));
        chk("max_next_grant", DW'(grant), DW'(4'b0100));
        chk("max_next_burst", DW'(burst), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
